// File: rtl/f1_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg
// Shared types and constants for the F1 start-light sequencer.
//   f1_state_t  : sequencer state encoding (IDLE / FILL / HOLD)
//   LFSR7_TAPS  : tap mask for the 7-bit Fibonacci LFSR, x^7 + x^6 + 1
//   lfsr7_step  : one shift of that LFSR (shift left, feedback into bit 0)
// ---------------------------------------------------------------------------
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } f1_state_t;

    localparam logic [6:0] LFSR7_TAPS = 7'b110_0000;

    // Maximal-length sequence (period 127) from any non-zero state.
    function automatic logic [6:0] lfsr7_step(input logic [6:0] q);
        return {q[5:0], ^(q & LFSR7_TAPS)};
    endfunction

endpackage

// File: rtl/f1_start_seq_lfsr7.sv
// ---------------------------------------------------------------------------
// lfsr7
// Free-running 7-bit Fibonacci LFSR used as the random source for the hold
// time. It shifts on every clock, so the value sampled at HOLD entry depends
// on how long after reset the sequence was triggered.
// Ports:
//   clk  in   clock
//   rst  in   async active-high reset, loads SEED
//   q    out  current LFSR state [6:0]
// ---------------------------------------------------------------------------
module lfsr7
    import f1_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h01
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] q
);

    logic [6:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= SEED;
        end else begin
            q_reg <= lfsr7_step(q_reg);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/f1_start_seq.sv
// ---------------------------------------------------------------------------
// f1_start_seq
// F1 start-light sequencer. A trigger in IDLE starts a thermometer fill of
// N_LIGHTS lamps, one lamp per en tick. Once all lamps are lit they stay on
// for HOLD_MIN + lfsr[HOLD_W-1:0] ticks, then go out together with a one-clock
// done pulse. abort cancels a running sequence without done.
// Ports:
//   clk       in   clock
//   rst       in   async active-high reset
//   en        in   tick strobe, advances fill / hold
//   trigger   in   start request, honoured only in IDLE
//   abort     in   cancel sequence, lamps off, no done
//   data_out  out  lamp pattern [N_LIGHTS-1:0], bit 0 = first lamp
//   busy      out  high in FILL or HOLD
//   done      out  one-clock pulse when lamps go out after a full hold
// ---------------------------------------------------------------------------
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int         N_LIGHTS = 8,
    parameter int         HOLD_MIN = 1,
    parameter int         HOLD_W   = 3,
    parameter logic [6:0] SEED     = 7'h01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                trigger,
    input  logic                abort,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W    = $clog2(N_LIGHTS + 1);
    localparam int HOLD_MAX = HOLD_MIN + (2 ** HOLD_W) - 1;
    localparam int HC_W     = $clog2(HOLD_MAX + 1);

    // Elaboration-time parameter checks.
    if (N_LIGHTS < 2 || N_LIGHTS > 32) begin : g_bad_n_lights
        $error("f1_start_seq: N_LIGHTS must be 2..32");
    end
    if (HOLD_MIN < 1) begin : g_bad_hold_min
        $error("f1_start_seq: HOLD_MIN must be >= 1");
    end
    if (HOLD_W < 1 || HOLD_W > 7) begin : g_bad_hold_w
        $error("f1_start_seq: HOLD_W must be 1..7");
    end
    if (SEED == 7'h00) begin : g_bad_seed
        $error("f1_start_seq: SEED must be non-zero");
    end

    f1_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [HC_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic             done_reg, done_next;
    logic [6:0]       lfsr_q;
    logic [HC_W-1:0]  hold_load;
    logic             unused_lfsr;

    lfsr7 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Only the low HOLD_W bits set the hold time; the rest are referenced
    // here so the full LFSR state stays visible.
    assign unused_lfsr = ^lfsr_q;
    assign hold_load   = HC_W'(HOLD_MIN) + HC_W'(lfsr_q[HOLD_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            hold_cnt_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            hold_cnt_reg <= hold_cnt_next;
            done_reg     <= done_next;
        end
    end

    // Priority inside each state: abort > en > trigger.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        hold_cnt_next = hold_cnt_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                // en is ignored here, so en+trigger together only starts FILL.
                if (!abort && trigger) begin
                    state_next = FILL;
                    count_next = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (en) begin
                    if (count_reg == CNT_W'(N_LIGHTS - 1)) begin
                        state_next    = HOLD;
                        count_next    = CNT_W'(N_LIGHTS);
                        hold_cnt_next = hold_load;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_next    = IDLE;
                    count_next    = '0;
                    hold_cnt_next = '0;
                end else if (en) begin
                    if (hold_cnt_reg == HC_W'(1)) begin
                        state_next    = IDLE;
                        count_next    = '0;
                        hold_cnt_next = '0;
                        done_next     = 1'b1;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                count_next    = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    // Thermometer decode: lamp gi is lit once count has passed it.
    for (genvar gi = 0; gi < N_LIGHTS; gi++) begin : g_lamp
        assign data_out[gi] = (state_reg == HOLD) ||
                              ((state_reg == FILL) && (count_reg > CNT_W'(gi)));
    end

    assign busy = (state_reg == FILL) || (state_reg == HOLD);
    assign done = done_reg;

endmodule

// File: tb/tb_f1_start_seq.sv
module tb_f1_start_seq;

    localparam logic [6:0] SEED = 7'h01;

    logic       clk;
    logic       rst;
    logic       en_a, trig_a, ab_a;
    logic       en_b, trig_b, ab_b;
    logic [7:0] data_a;
    logic [3:0] data_b;
    logic       busy_a, done_a, busy_b, done_b;

    f1_start_seq #(.N_LIGHTS(8), .HOLD_MIN(1), .HOLD_W(3), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .trigger(trig_a), .abort(ab_a),
        .data_out(data_a), .busy(busy_a), .done(done_a)
    );

    f1_start_seq #(.N_LIGHTS(4), .HOLD_MIN(2), .HOLD_W(1), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .trigger(trig_b), .abort(ab_b),
        .data_out(data_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent LFSR model: x^7 + x^6 + 1, shift left, free-running.
    logic [6:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    typedef struct {
        logic       en;
        logic       trig;
        logic [7:0] data;
        logic       busy;
        bit         last;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end else begin
            $display("ok   %s: %0h", nm, got);
        end
    endtask

    // One clock of stimulus on dut A (sel=0) or dut B (sel=1). The expected
    // outputs after the edge go into the scoreboard when the stimulus is
    // driven and are popped and compared #1 after the edge.
    task automatic cyc(input bit sel, input logic e, input logic t, input logic a,
                       input logic [7:0] xd, input logic xb, input logic xdn,
                       input string nm);
        exp_t       x;
        logic [7:0] gd;
        logic       gb, gdn;
        @(negedge clk);
        en_a = 1'b0; trig_a = 1'b0; ab_a = 1'b0;
        en_b = 1'b0; trig_b = 1'b0; ab_b = 1'b0;
        if (!sel) begin en_a = e; trig_a = t; ab_a = a; end
        else      begin en_b = e; trig_b = t; ab_b = a; end
        x.data = xd; x.busy = xb; x.done = xdn; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            x   = sb.pop_front();
            gd  = sel ? {4'h0, data_b} : data_a;
            gb  = sel ? busy_b : busy_a;
            gdn = sel ? done_b : done_a;
            if (gd !== x.data || gb !== x.busy || gdn !== x.done) begin
                bad++;
                $display("FAIL %s: got data=%h busy=%b done=%b want data=%h busy=%b done=%b",
                         x.name, gd, gb, gdn, x.data, x.busy, x.done);
            end else begin
                $display("ok   %s: data=%h busy=%b done=%b", x.name, gd, gb, gdn);
            end
        end
    endtask

    vec_t tbl[33];
    int   hold;
    int   n;

    initial begin
        rst = 1'b1;
        en_a = 1'b0; trig_a = 1'b0; ab_a = 1'b0;
        en_b = 1'b0; trig_b = 1'b0; ab_b = 1'b0;

        // Fill sequence table for dut A: trigger, then en every 4th clk.
        tbl[0] = '{en: 1'b0, trig: 1'b1, data: 8'h00, busy: 1'b1, last: 1'b0};
        n = 1;
        for (int k = 1; k <= 8; k++) begin
            for (int g = 0; g < 3; g++) begin
                tbl[n] = '{en: 1'b0, trig: 1'b0, data: 8'((1 << (k - 1)) - 1),
                           busy: 1'b1, last: 1'b0};
                n++;
            end
            tbl[n] = '{en: 1'b1, trig: 1'b0, data: 8'((1 << k) - 1),
                       busy: 1'b1, last: (k == 8)};
            n++;
        end

        // 1: reset state, then quiet idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst data_a", 32'(data_a), 32'h0);
        chk("rst busy_a", 32'(busy_a), 32'h0);
        chk("rst done_a", 32'(done_a), 32'h0);
        chk("rst lfsr", 32'(dut_a.lfsr_q), 32'(SEED));
        chk("rst data_b", 32'(data_b), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // 2: table-driven fill.
        hold = 0;
        for (int i = 0; i < 33; i++) begin
            if (tbl[i].last) begin
                chk("lfsr at hold entry", 32'(dut_a.lfsr_q), 32'(lfsr_m));
                hold = 1 + int'(lfsr_m[2:0]);
            end
            cyc(0, tbl[i].en, tbl[i].trig, 1'b0, tbl[i].data, tbl[i].busy, 1'b0, "fill");
        end

        // 3: hold for the expected number of ticks; trigger pulses in between are ignored.
        for (int j = 1; j <= hold; j++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "hold trig ignored");
            if (j < hold) cyc(0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, "hold en");
            else          cyc(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "hold last en done");
        end
        cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "done one clk");

        // 4: en+trigger in IDLE, trigger during FILL ignored, abort after 3rd en.
        cyc(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "en+trig idle");
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "fill trig ignored");
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, "fill en1");
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "fill trig ignored");
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, "fill en2");
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, "fill en3");
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "abort fill");
        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "after abort");
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "abort idle");
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "trig");
        for (int k = 1; k <= 8; k++)
            cyc(0, 1'b1, 1'b0, 1'b0, 8'((1 << k) - 1), 1'b1, 1'b0, "fill fast");
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "abort hold");
        cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "after abort hold");

        // 5: 4-lamp instance, hold 2 or 3 ticks, trigger on done cycle restarts.
        for (int r = 0; r < 2; r++) begin
            cyc(1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "b trig");
            for (int k = 1; k <= 4; k++) begin
                if (k == 4) begin
                    chk("b lfsr at hold entry", 32'(dut_b.lfsr_q), 32'(lfsr_m));
                    hold = 2 + int'(lfsr_m[0]);
                end
                cyc(1, 1'b1, 1'b0, 1'b0, 8'((1 << k) - 1), 1'b1, 1'b0, "b fill");
                cyc(1, 1'b0, 1'b0, 1'b0, 8'((1 << k) - 1), 1'b1, 1'b0, "b gap");
            end
            for (int j = 1; j <= hold; j++) begin
                if (j < hold) cyc(1, 1'b1, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0, "b hold en");
                else          cyc(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "b done");
            end
            // Trigger driven during the done cycle itself.
            cyc(1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "b restart on done");
            cyc(1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, "b restart en1");
            cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "b abort");
        end

        // 6: async reset mid-HOLD clears outputs before the next edge.
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "trig");
        for (int k = 1; k <= 8; k++)
            cyc(0, 1'b1, 1'b0, 1'b0, 8'((1 << k) - 1), 1'b1, 1'b0, "fill fast");
        @(negedge clk);
        en_a = 1'b0; trig_a = 1'b0; ab_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst data", 32'(data_a), 32'h0);
        chk("async rst busy", 32'(busy_a), 32'h0);
        chk("async rst done", 32'(done_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst lfsr reload", 32'(dut_a.lfsr_q), 32'(SEED));
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "after rst");

        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
